// File: rtl/boxcar_filter_mc.sv
// boxcar_filter_mc
// Multi-channel moving-average filter with a runtime-selectable window of 2**k samples.
// Time-multiplexed samples carry a channel tag. Each channel has its own history buffer,
// running sum, write pointer and fill count. One registered average is produced per
// accepted sample.
//
// Ports
//   i_clk       clock, rising edge
//   i_reset     asynchronous active-high reset
//   i_ce        sample strobe
//   i_channel   channel tag of i_data; out-of-range channels are ignored
//   i_data      signed sample
//   i_log2_len  window exponent k, clamped to MAX_LOG2_LEN
//   i_flush     synchronous clear of all channel state
//   o_ce        output strobe, one cycle after each accepted sample
//   o_channel   channel of o_data
//   o_data      signed average (sum >>> k, optionally rounded)
//   o_full      window of o_channel was full when o_data was produced
//   o_sum       running sum of o_channel after the update
module boxcar_filter_mc #(
   parameter int DATA_WIDTH   = 8,
   parameter int NUM_CHANNELS = 4,
   parameter int MAX_LOG2_LEN = 4,
   parameter int ROUND        = 0,
   parameter int CH_WIDTH     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
   parameter int LEN_WIDTH    = $clog2(MAX_LOG2_LEN + 1)
) (
   input  logic                                      i_clk,
   input  logic                                      i_reset,
   input  logic                                      i_ce,
   input  logic        [CH_WIDTH-1:0]                i_channel,
   input  logic signed [DATA_WIDTH-1:0]              i_data,
   input  logic        [LEN_WIDTH-1:0]               i_log2_len,
   input  logic                                      i_flush,
   output logic                                      o_ce,
   output logic        [CH_WIDTH-1:0]                o_channel,
   output logic signed [DATA_WIDTH-1:0]              o_data,
   output logic                                      o_full,
   output logic signed [DATA_WIDTH+MAX_LOG2_LEN-1:0] o_sum
);

   localparam int SumWidth  = DATA_WIDTH + MAX_LOG2_LEN;
   localparam int Depth     = 2 ** MAX_LOG2_LEN;
   localparam int FillWidth = MAX_LOG2_LEN + 1;
   localparam logic [LEN_WIDTH-1:0] MaxK = LEN_WIDTH'(MAX_LOG2_LEN);

   logic signed [DATA_WIDTH-1:0]   mem_q  [NUM_CHANNELS][Depth];
   logic        [MAX_LOG2_LEN-1:0] wptr_q [NUM_CHANNELS];
   logic        [FillWidth-1:0]    fill_q [NUM_CHANNELS];
   logic signed [SumWidth-1:0]     sum_q  [NUM_CHANNELS];
   logic        [LEN_WIDTH-1:0]    k_q;
   // Set by reset: the first edge afterwards loads k without treating it as a change.
   logic                           k_load_q;

   logic        [LEN_WIDTH-1:0]    k_in;
   logic        [LEN_WIDTH-1:0]    k_eff;
   logic                           clear;
   logic                           ch_valid;
   logic                           accept;
   logic        [FillWidth-1:0]    win;
   logic                           is_full;
   logic        [MAX_LOG2_LEN-1:0] ev_addr;
   logic signed [DATA_WIDTH-1:0]   evicted;
   logic signed [SumWidth-1:0]     new_sum;
   logic        [FillWidth-1:0]    new_fill;
   logic signed [SumWidth-1:0]     rnd;
   logic signed [SumWidth-1:0]     rounded;

   always_comb begin
      k_in     = (i_log2_len > MaxK) ? MaxK : i_log2_len;
      k_eff    = k_load_q ? k_in : k_q;
      clear    = i_flush || (!k_load_q && (k_in != k_q));
      ch_valid = 32'(i_channel) < NUM_CHANNELS;
      accept   = i_ce && ch_valid && !clear;

      win      = FillWidth'(1) << k_eff;
      is_full  = ch_valid && (fill_q[i_channel] == win);
      // Read before write: for k = MAX_LOG2_LEN this is the slot about to be overwritten.
      ev_addr  = wptr_q[i_channel] - win[MAX_LOG2_LEN-1:0];
      evicted  = is_full ? mem_q[i_channel][ev_addr] : '0;
      new_sum  = sum_q[i_channel] + SumWidth'(i_data) - SumWidth'(evicted);
      new_fill = is_full ? fill_q[i_channel] : fill_q[i_channel] + FillWidth'(1);

      rnd = '0;
      if (ROUND != 0 && k_eff != '0) begin
         rnd = SumWidth'(1) << (k_eff - LEN_WIDTH'(1));
      end
      rounded = new_sum + rnd;
   end

   // History buffer is never cleared; fill gates every eviction.
   always_ff @(posedge i_clk) begin
      if (accept) begin
         mem_q[i_channel][wptr_q[i_channel]] <= i_data;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         k_q       <= '0;
         k_load_q  <= 1'b1;
         o_ce      <= 1'b0;
         o_channel <= '0;
         o_data    <= '0;
         o_full    <= 1'b0;
         o_sum     <= '0;
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            wptr_q[c] <= '0;
            fill_q[c] <= '0;
            sum_q[c]  <= '0;
         end
      end else begin
         k_q      <= k_in;
         k_load_q <= 1'b0;
         o_ce     <= accept;
         if (clear) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
               wptr_q[c] <= '0;
               fill_q[c] <= '0;
               sum_q[c]  <= '0;
            end
         end else if (accept) begin
            wptr_q[i_channel] <= wptr_q[i_channel] + MAX_LOG2_LEN'(1);
            fill_q[i_channel] <= new_fill;
            sum_q[i_channel]  <= new_sum;
            o_channel         <= i_channel;
            o_data            <= DATA_WIDTH'(rounded >>> k_eff);
            o_full            <= (new_fill == win);
            o_sum             <= new_sum;
         end
      end
   end

endmodule

// File: tb/tb_boxcar_filter_mc.sv
module tb_boxcar_filter_mc;

   logic              clk;
   logic              rst;
   logic              ce;
   logic        [1:0] ch;
   logic signed [7:0] din;
   logic        [2:0] log2_len;
   logic              flush;

   logic               o_ce0, o_full0;
   logic         [1:0] o_ch0;
   logic signed  [7:0] o_data0;
   logic signed [11:0] o_sum0;
   logic               o_ce1, o_full1;
   logic         [1:0] o_ch1;
   logic signed  [7:0] o_data1;
   logic signed [11:0] o_sum1;

   int errors = 0;
   int checks = 0;

   // Truncating, 4 channels
   boxcar_filter_mc #(.ROUND(0), .NUM_CHANNELS(4)) dut0 (
      .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_channel(ch), .i_data(din),
      .i_log2_len(log2_len), .i_flush(flush), .o_ce(o_ce0), .o_channel(o_ch0),
      .o_data(o_data0), .o_full(o_full0), .o_sum(o_sum0)
   );

   // Rounding, 3 channels so that channel 3 is out of range
   boxcar_filter_mc #(.ROUND(1), .NUM_CHANNELS(3)) dut1 (
      .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_channel(ch), .i_data(din),
      .i_log2_len(log2_len), .i_flush(flush), .o_ce(o_ce1), .o_channel(o_ch1),
      .o_data(o_data1), .o_full(o_full1), .o_sum(o_sum1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one cycle of inputs, wait for the edge, then sample point is #1 after it.
   task automatic drive(input logic c_e, input logic fl, input logic [1:0] c, input int d);
      ce = c_e; flush = fl; ch = c; din = 8'(d);
      @(posedge clk);
      #1;
      ce = 1'b0; flush = 1'b0;
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      checks++; if (o_ce0 !== 1'b0) begin errors++; $display("FAIL reset_o_ce got %0d want 0", o_ce0); end
      checks++; if (o_data0 !== 8'sd0) begin errors++; $display("FAIL reset_o_data got %0d want 0", o_data0); end
      checks++; if (o_sum0 !== 12'sd0) begin errors++; $display("FAIL reset_o_sum got %0d want 0", o_sum0); end
      checks++; if (o_full0 !== 1'b0) begin errors++; $display("FAIL reset_o_full got %0d want 0", o_full0); end
      checks++; if (o_ch0 !== 2'd0) begin errors++; $display("FAIL reset_o_channel got %0d want 0", o_ch0); end
      rst = 1'b0;
      drive(0, 0, 0, 0);
   endtask

   task automatic test_basic();
      int smp [5] = '{4, 8, 12, 16, 20};
      int avg [5] = '{1, 3, 6, 10, 14};
      int sm  [5] = '{4, 12, 24, 40, 56};
      int fl  [5] = '{0, 0, 0, 1, 1};
      log2_len = 3'd2;
      drive(0, 1, 0, 0);
      checks++; if (o_ce0 !== 1'b0) begin errors++; $display("FAIL flush_no_ce got %0d want 0", o_ce0); end
      for (int i = 0; i < 5; i++) begin
         drive(1, 0, 0, smp[i]);
         checks++; if (o_ce0 !== 1'b1) begin errors++; $display("FAIL basic_ce[%0d] got %0d want 1", i, o_ce0); end
         checks++; if (o_data0 !== 8'(avg[i])) begin errors++; $display("FAIL basic_data[%0d] got %0d want %0d", i, o_data0, avg[i]); end
         checks++; if (o_sum0 !== 12'(sm[i])) begin errors++; $display("FAIL basic_sum[%0d] got %0d want %0d", i, o_sum0, sm[i]); end
         checks++; if (o_full0 !== 1'(fl[i])) begin errors++; $display("FAIL basic_full[%0d] got %0d want %0d", i, o_full0, fl[i]); end
      end
      drive(0, 0, 0, 0);
      checks++; if (o_ce0 !== 1'b0) begin errors++; $display("FAIL basic_ce_single got %0d want 0", o_ce0); end
   endtask

   task automatic test_back_to_back();
      log2_len = 3'd1;
      drive(0, 0, 0, 0);
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 4; c++) begin
            drive(1, 0, 2'(c), 10 * (c + 1));
            checks++; if (o_ch0 !== 2'(c)) begin errors++; $display("FAIL rr_channel[%0d,%0d] got %0d want %0d", r, c, o_ch0, c); end
            checks++; if (o_data0 !== 8'((r == 0) ? 5 * (c + 1) : 10 * (c + 1))) begin errors++; $display("FAIL rr_data[%0d,%0d] got %0d", r, c, o_data0); end
            checks++; if (o_full0 !== (r != 0)) begin errors++; $display("FAIL rr_full[%0d,%0d] got %0d want %0d", r, c, o_full0, r != 0); end
            if (r == 2) begin
               checks++; if (o_sum0 !== 12'(20 * (c + 1))) begin errors++; $display("FAIL rr_sum[%0d] got %0d want %0d", c, o_sum0, 20 * (c + 1)); end
            end
         end
      end
   endtask

   task automatic test_round();
      int smp [4] = '{-1, -1, -1, -2};
      int tr  [4] = '{-1, -1, -1, -2};
      int rn  [4] = '{0, 0, -1, -1};
      int sm  [4] = '{-1, -2, -3, -5};
      log2_len = 3'd2;
      drive(0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0, smp[i]);
         checks++; if (o_data0 !== 8'(tr[i])) begin errors++; $display("FAIL trunc_data[%0d] got %0d want %0d", i, o_data0, tr[i]); end
         checks++; if (o_data1 !== 8'(rn[i])) begin errors++; $display("FAIL round_data[%0d] got %0d want %0d", i, o_data1, rn[i]); end
         checks++; if (o_sum1 !== 12'(sm[i])) begin errors++; $display("FAIL round_sum[%0d] got %0d want %0d", i, o_sum1, sm[i]); end
      end
   endtask

   task automatic test_invalid_channel();
      drive(1, 0, 2'd3, 100);
      checks++; if (o_ce1 !== 1'b0) begin errors++; $display("FAIL invalid_ch_ce got %0d want 0", o_ce1); end
      checks++; if (o_ce0 !== 1'b1) begin errors++; $display("FAIL valid_ch3_ce got %0d want 1", o_ce0); end
      // Channel 0 of the 3-channel filter must be untouched: -5 - (-1) + 0 = -4
      drive(1, 0, 2'd0, 0);
      checks++; if (o_sum1 !== -12'sd4) begin errors++; $display("FAIL invalid_ch_sum got %0d want -4", o_sum1); end
      checks++; if (o_data1 !== -8'sd1) begin errors++; $display("FAIL invalid_ch_data got %0d want -1", o_data1); end
   endtask

   task automatic test_max_window();
      int es, ea;
      log2_len = 3'd6; // clamps to 4
      drive(0, 0, 0, 0);
      for (int i = 0; i < 60; i++) begin
         if (i < 40) begin
            es = 127 * ((i + 1 < 16) ? i + 1 : 16);
         end else if (i - 40 < 16) begin
            es = 127 * (15 - (i - 40)) - 128 * (i - 40 + 1);
         end else begin
            es = -2048;
         end
         ea = es >>> 4;
         drive(1, 0, 2'd1, (i < 40) ? 127 : -128);
         checks++; if (o_sum0 !== 12'(es)) begin errors++; $display("FAIL max_sum[%0d] got %0d want %0d", i, o_sum0, es); end
         checks++; if (o_data0 !== 8'(ea)) begin errors++; $display("FAIL max_data[%0d] got %0d want %0d", i, o_data0, ea); end
         checks++; if (o_full0 !== (i >= 15)) begin errors++; $display("FAIL max_full[%0d] got %0d want %0d", i, o_full0, i >= 15); end
      end
   endtask

   task automatic test_window_change();
      log2_len = 3'd2;
      drive(0, 0, 0, 0);
      drive(1, 0, 0, 4);
      drive(1, 0, 0, 4);
      checks++; if (o_data0 !== 8'sd2) begin errors++; $display("FAIL wc_pre_data got %0d want 2", o_data0); end
      log2_len = 3'd3;
      drive(1, 0, 0, 50);
      checks++; if (o_ce0 !== 1'b0) begin errors++; $display("FAIL wc_dropped_ce got %0d want 0", o_ce0); end
      checks++; if (o_data0 !== 8'sd2) begin errors++; $display("FAIL wc_hold_data got %0d want 2", o_data0); end
      checks++; if (o_sum0 !== 12'sd8) begin errors++; $display("FAIL wc_hold_sum got %0d want 8", o_sum0); end
      for (int c = 0; c < 4; c++) begin
         drive(1, 0, 2'(c), 8);
         checks++; if (o_data0 !== 8'sd1) begin errors++; $display("FAIL wc_data[%0d] got %0d want 1", c, o_data0); end
         checks++; if (o_sum0 !== 12'sd8) begin errors++; $display("FAIL wc_sum[%0d] got %0d want 8", c, o_sum0); end
         checks++; if (o_full0 !== 1'b0) begin errors++; $display("FAIL wc_full[%0d] got %0d want 0", c, o_full0); end
      end
   endtask

   task automatic test_async_reset();
      log2_len = 3'd2;
      drive(0, 0, 0, 0);
      drive(1, 0, 0, 40);
      checks++; if (o_data0 !== 8'sd10) begin errors++; $display("FAIL ar_pre_data got %0d want 10", o_data0); end
      ce = 1'b1; ch = 2'd0; din = 8'sd20;
      #2 rst = 1'b1;
      #1;
      checks++; if (o_ce0 !== 1'b0) begin errors++; $display("FAIL ar_ce got %0d want 0", o_ce0); end
      checks++; if (o_data0 !== 8'sd0) begin errors++; $display("FAIL ar_data got %0d want 0", o_data0); end
      checks++; if (o_sum0 !== 12'sd0) begin errors++; $display("FAIL ar_sum got %0d want 0", o_sum0); end
      ce = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      drive(0, 0, 0, 0);
      checks++; if (o_ce0 !== 1'b0) begin errors++; $display("FAIL ar_no_ce got %0d want 0", o_ce0); end
      drive(1, 0, 0, 16);
      checks++; if (o_data0 !== 8'sd4) begin errors++; $display("FAIL ar_first_data got %0d want 4", o_data0); end
      checks++; if (o_sum0 !== 12'sd16) begin errors++; $display("FAIL ar_first_sum got %0d want 16", o_sum0); end
      checks++; if (o_full0 !== 1'b0) begin errors++; $display("FAIL ar_first_full got %0d want 0", o_full0); end
   endtask

   initial begin
      rst = 1'b1; ce = 1'b0; ch = 2'd0; din = 8'sd0; log2_len = 3'd2; flush = 1'b0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_round();
      test_invalid_channel();
      test_max_window();
      test_window_change();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
